// File: rtl/pipe_pkg.sv
// Shared types and constants for the DPCPU pipeline stage registers.
package pipe_pkg;

    // Occupancy state of a stage register: nothing held, one entry, or
    // two entries with the second parked in the skid register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Bubble encoding the CPU top passes as BUBBLE_VAL (addi x0, x0, 0).
    localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count requested cycles until the counter is full, then hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter int               SKID       = 1,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_e      state;
    logic [WIDTH-1:0] main_q;
    logic             in_xfer;
    logic             stall;

    // q only ever comes from the main register, so downstream sees a flop output.
    assign q         = main_q;
    assign out_valid = (state != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign stall     = out_valid & ~out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] skid_q;
            logic             ready_q;

            // in_ready is a flop: it is known before the cycle starts, which
            // is why a second entry is needed to catch the word in flight.
            assign in_ready = ready_q;

            // Occupancy FSM for the two-entry version; ready_q tracks "next state is not SKID".
            always_ff @(posedge clk) begin
                if (clr) begin
                    main_q  <= RESET_VAL;
                    skid_q  <= BUBBLE_VAL;
                    state   <= ST_EMPTY;
                    ready_q <= 1'b1;
                end else if (flush) begin
                    main_q  <= BUBBLE_VAL;
                    skid_q  <= BUBBLE_VAL;
                    state   <= ST_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            ready_q <= 1'b1;
                            if (in_xfer) begin
                                main_q <= d;
                                state  <= ST_HOLD;
                            end else begin
                                main_q <= BUBBLE_VAL;
                            end
                        end
                        ST_HOLD: begin
                            if (out_ready) begin
                                if (in_xfer) begin
                                    main_q <= d;
                                end else begin
                                    main_q <= BUBBLE_VAL;
                                    state  <= ST_EMPTY;
                                end
                            end else if (in_xfer) begin
                                skid_q  <= d;
                                state   <= ST_SKID;
                                ready_q <= 1'b0;
                            end
                        end
                        ST_SKID: begin
                            if (out_ready) begin
                                main_q  <= skid_q;
                                state   <= ST_HOLD;
                                ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            main_q  <= BUBBLE_VAL;
                            state   <= ST_EMPTY;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_flop
            // Without a skid entry the stage can only accept when its single
            // entry is leaving or already empty.
            assign in_ready = out_ready | ~out_valid;

            // Single-entry stall flop: a stall simply holds main_q.
            always_ff @(posedge clk) begin
                if (clr) begin
                    main_q <= RESET_VAL;
                    state  <= ST_EMPTY;
                end else if (flush) begin
                    main_q <= BUBBLE_VAL;
                    state  <= ST_EMPTY;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (in_xfer) begin
                                main_q <= d;
                                state  <= ST_HOLD;
                            end else begin
                                main_q <= BUBBLE_VAL;
                            end
                        end
                        ST_HOLD: begin
                            if (out_ready) begin
                                if (in_xfer) begin
                                    main_q <= d;
                                end else begin
                                    main_q <= BUBBLE_VAL;
                                    state  <= ST_EMPTY;
                                end
                            end
                        end
                        default: begin
                            main_q <= BUBBLE_VAL;
                            state  <= ST_EMPTY;
                        end
                    endcase
                end
            end
        end
    endgenerate

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (stall),
        .count (stall_cnt)
    );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the DPCPU pipeline. It generalises the 32-bit PC/stage flop with stall to any width, and adds:
- valid/ready handshaking
- an optional 2-entry skid buffer
- flush-to-bubble
- a saturating stall-cycle counter

It sits between adjacent pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and in front of the PC.

Parameters:
WIDTH, 32, payload width in bits
RESET_VAL, 0, payload value loaded on clr (PC reset value when used as PC register)
BUBBLE_VAL, 0, payload value presented when stage holds no valid data (NOP encoding)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  synchronous reset, active-high
flush  in  1  discard all held data, insert bubble
in_valid  in  1  upstream data valid
in_ready  out  1  stage can accept d this cycle
d  in  WIDTH  upstream payload
out_valid  out  1  q is valid
out_ready  in  1  downstream accepts q this cycle (0 = stall)
q  out  WIDTH  payload to downstream
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (clr=1 at edge):
  - main register <= RESET_VAL; skid register <= BUBBLE_VAL.
  - state <= EMPTY; out_valid=0; stall_cnt=0.
  - in_ready=1 from the first cycle after reset.
- Priority each edge: clr > flush > normal operation.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Latency d->q is 1 cycle when not stalled.
- q is driven from the main register only. out_valid = (state != EMPTY).
- SKID=1 states:
  - EMPTY: input transfer -> main<=d, go HOLD. Otherwise main<=BUBBLE_VAL.
  - HOLD:
    - out_ready & in_valid -> main<=d, stay HOLD.
    - out_ready & !in_valid -> main<=BUBBLE_VAL, go EMPTY.
    - !out_ready & in_valid -> skid<=d, go SKID.
    - !out_ready & !in_valid -> hold.
  - SKID: in_ready=0 and d is ignored.
    - out_ready -> main<=skid, go HOLD.
    - !out_ready -> hold both registers.
  - in_ready is registered: it is 1 in the cycle after entering EMPTY or HOLD, and 0 while in SKID.
- SKID=0:
  - No skid register; states are EMPTY and HOLD only.
  - in_ready = out_ready | !out_valid (combinational).
  - Stall (out_valid & !out_ready) holds main unchanged, exactly like a stall flop.
- flush=1: state <= EMPTY, main <= BUBBLE_VAL, skid discarded, any same-cycle input dropped. in_ready=1 in the next cycle.
- stall_cnt:
  - Increments when out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by clr; flush does not clear it.
- Simultaneous events:
  - clr with flush: reset values apply (RESET_VAL, not BUBBLE_VAL).
  - flush with an output transfer: the output transfer completes this cycle; the stage is empty after the edge.
- No data loss and no duplication: every accepted d appears exactly once on q with out_valid=1, in order, unless flushed.

Decomposition:
- Package pipe_pkg holds:
  - the state enum (EMPTY, HOLD, SKID) with 2-bit encoding
  - a default NOP constant for BUBBLE_VAL used by the CPU top
- One sub-module, pipe_sat_cnt, the saturating counter (parameter CNT_W, inputs clk/clr/inc). All other logic is inline.

Test Plan:
1. Reset: clr=1 for 2 cycles, then release -> q=RESET_VAL (0x00000000), out_valid=0, in_ready=1, stall_cnt=0.
2. Streaming: in_valid=1 and out_ready=1 constant, d=1,2,3,4 on successive cycles -> q=1,2,3,4 one cycle later each, out_valid=1 throughout, stall_cnt stays 0.
3. Skid stall (SKID=1):
   - Stimulus: send d=0xA then 0xB; drop out_ready to 0 for 3 cycles while 0xB arrives.
   - During the stall: q holds 0xA, 0xB is captured in skid, in_ready=0, stall_cnt=3.
   - On out_ready=1: q=0xA is taken, then q=0xB the next cycle. No loss and no duplicate.
4. Flush: stage in SKID holding 0x10/0x11, assert flush with in_valid=1 and d=0x12 -> next cycle out_valid=0, q=BUBBLE_VAL, 0x12 dropped, in_ready=1.
5. SKID=0 stall: out_valid=1, q=0x55, out_ready=0 with in_valid=1 and d=0x66 -> in_ready=0 and q stays 0x55 every stalled cycle. When out_ready=1, q=0x66 the next cycle.
6. Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cnt reaches 15 and stays. Then clr -> stall_cnt=0.
